// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Two-stage execute wrapper around an external RV32 integer ALU.
//   Stage 1 decodes funct3/funct7 into a 4-bit ALU control code and registers
//   the operands that drive the ALU. Stage 2 captures the ALU result and zero
//   flag into an output register. Both stages use a valid/ready handshake, so
//   the pipeline sustains one op per cycle and stalls cleanly on backpressure.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready never depends on in_valid)
//   funct3, funct7_5,
//   funct7_0, is_imm    instruction fields used for decode
//   rs1_val, rs2_val,
//   imm, rd             operands and destination index
//   alu_a, alu_b,
//   alu_op              registered operands / control code to the ALU
//   alu_y, alu_zero     combinational ALU result and zero flag
//   out_valid/out_ready downstream handshake
//   out_result, out_zero,
//   out_rd, out_illegal registered result bundle
//
// Optional feature (macro ALU_ISSUE_STAGE_PERF_EN):
//   Adds perf_ops (completed transfers) and perf_stall (cycles with a result
//   waiting on out_ready), both 32-bit wrapping counters reset to 0.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            is_imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [RD_W-1:0] rd,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_y,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
`ifdef ALU_ISSUE_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1110;

  logic            r_s1Valid;
  logic            r_s2Valid;
  logic [RD_W-1:0] r_s1Rd;
  logic            r_s1Illegal;

  logic            w_advance1;
  logic            w_advance2;
  logic [3:0]      w_aluOp;
  logic            w_illegal;
  logic            w_isShift;
  logic [XLEN-1:0] w_opB;

  // Stage 2 can move when it is empty or its result is being taken; stage 1
  // can move when it is empty or stage 2 is moving. This lets a full pipe
  // accept, advance and emit in the same edge with no bubble.
  assign w_advance2 = !r_s2Valid || out_ready;
  assign w_advance1 = !r_s1Valid || w_advance2;
  assign in_ready   = w_advance1;
  assign out_valid  = r_s2Valid;

  // Decode funct3/funct7 into the ALU control code. Anything without an ALU
  // encoding (signed SLT, SRA, conflicting funct7 bits, M-extension ops other
  // than MUL) is flagged illegal and forced to code 0000 so the ALU yields 0.
  always_comb begin
    w_aluOp   = OP_NONE;
    w_illegal = 1'b0;
    w_isShift = 1'b0;
    case (funct3)
      3'b000: begin
        if (!is_imm && funct7_5 && funct7_0) begin
          w_illegal = 1'b1;
        end else if (!is_imm && funct7_5) begin
          w_aluOp = OP_SUB;
        end else if (!is_imm && funct7_0) begin
          w_aluOp = OP_MUL;
        end else begin
          w_aluOp = OP_ADD;
        end
      end
      3'b111: w_aluOp = OP_AND;
      3'b110: w_aluOp = OP_OR;
      3'b100: w_aluOp = OP_XOR;
      3'b011: w_aluOp = OP_SLTU;
      3'b010: w_illegal = 1'b1;
      3'b001: begin
        w_aluOp   = OP_SLL;
        w_isShift = 1'b1;
      end
      3'b101: begin
        if (funct7_5) begin
          w_illegal = 1'b1;
        end else begin
          w_aluOp   = OP_SRL;
          w_isShift = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    // Register-form M-extension ops other than MUL are not handled here.
    if (!is_imm && funct7_0 && (funct3 != 3'b000)) begin
      w_illegal = 1'b1;
    end
    if (w_illegal) begin
      w_aluOp   = OP_NONE;
      w_isShift = 1'b0;
    end
  end

  // Operand b selection; shift amounts only use the low five bits, so the
  // upper bits are cleared before they reach the ALU.
  always_comb begin
    w_opB = is_imm ? imm : rs2_val;
    if (w_isShift) begin
      w_opB = {{(XLEN-5){1'b0}}, w_opB[4:0]};
    end
  end

  // Stage 1: the valid bit follows in_valid whenever the stage advances; the
  // payload only loads on an actual transfer so it holds during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_NONE;
      r_s1Rd      <= '0;
      r_s1Illegal <= 1'b0;
    end else if (w_advance1) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        alu_a       <= rs1_val;
        alu_b       <= w_opB;
        alu_op      <= w_aluOp;
        r_s1Rd      <= rd;
        r_s1Illegal <= w_illegal;
      end
    end
  end

  // Stage 2: capture the ALU result whenever stage 1 holds a live op and the
  // output register is free; otherwise keep the result stable for MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (w_advance2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        out_result  <= alu_y;
        out_zero    <= alu_zero;
        out_rd      <= r_s1Rd;
        out_illegal <= r_s1Illegal;
      end
    end
  end

`ifdef ALU_ISSUE_STAGE_PERF_EN
  // Performance counters: completed result transfers and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (r_s2Valid && out_ready) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (r_s2Valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed self-checking bench for alu_issue_stage. A small behavioural ALU
// stands in for the external ALU instance. Expected values are hand-computed
// constants per vector.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        funct7_0;
  logic        is_imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] aluY;
  logic        aluZero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_ISSUE_STAGE_PERF_EN
  logic [31:0] perfOps;
  logic [31:0] perfStall;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .funct7_0   (funct7_0),
    .is_imm     (is_imm),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .imm        (imm),
    .rd         (rd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (aluY),
    .alu_zero   (aluZero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .out_illegal(out_illegal)
`ifdef ALU_ISSUE_STAGE_PERF_EN
    ,
    .perf_ops   (perfOps),
    .perf_stall (perfStall)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external combinational ALU.
  always_comb begin
    aluY = 32'd0;
    case (alu_op)
      4'b0100: aluY = alu_a + alu_b;
      4'b1001: aluY = alu_a - alu_b;
      4'b1110: aluY = alu_a * alu_b;
      4'b0001: aluY = alu_a & alu_b;
      4'b0010: aluY = alu_a | alu_b;
      4'b0111: aluY = alu_a ^ alu_b;
      4'b1100: aluY = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b0011: aluY = alu_a << alu_b[4:0];
      4'b1010: aluY = alu_a >> alu_b[4:0];
      default: aluY = 32'd0;
    endcase
    aluZero = (aluY == 32'd0);
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op on the upstream interface.
  task automatic applyStimulus(input logic [2:0] f3, input logic f75, input logic f70,
                               input logic isImm, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] immV, input logic [4:0] rdV);
    funct3   = f3;
    funct7_5 = f75;
    funct7_0 = f70;
    is_imm   = isImm;
    rs1_val  = a;
    rs2_val  = b;
    imm      = immV;
    rd       = rdV;
    in_valid = 1'b1;
  endtask

  // Issue one op into an idle pipe and check decode plus the result bundle.
  task automatic runOne(input string tag, input logic [2:0] f3, input logic f75, input logic f70,
                        input logic isImm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] immV, input logic [4:0] rdV,
                        input logic [3:0] expOp, input logic [31:0] expB,
                        input logic [31:0] expRes, input logic expZero, input logic expIll);
    applyStimulus(f3, f75, f70, isImm, a, b, immV, rdV);
    tick;
    in_valid = 1'b0;
    checkOutput({tag, "_op"}, {28'd0, alu_op}, {28'd0, expOp});
    checkOutput({tag, "_b"}, alu_b, expB);
    checkOutput({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
    tick;
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_res"}, out_result, expRes);
    checkOutput({tag, "_zero"}, {31'd0, out_zero}, {31'd0, expZero});
    checkOutput({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rdV});
    checkOutput({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, expIll});
  endtask

  initial begin
    int nextIn;
    int nextOut;
    int validCount;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    in_valid = 1'b0;

    // Reset state.
    tick;
    tick;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_op", {28'd0, alu_op}, 32'd0);
    checkOutput("rst_a", alu_a, 32'd0);
    checkOutput("rst_res", out_result, 32'd0);
`ifdef ALU_ISSUE_STAGE_PERF_EN
    checkOutput("rst_perf_ops", perfOps, 32'd0);
`endif
    rst_n = 1'b1;
    tick;

    // Directed single-op vectors.
    runOne("add",   3'b000, 1'b0, 1'b0, 1'b0, 32'd5,      32'd7,          32'd0,     5'd3,  4'b0100, 32'd7,      32'd12,     1'b0, 1'b0);
    runOne("sub",   3'b000, 1'b1, 1'b0, 1'b0, 32'h1234,   32'h1234,       32'd0,     5'd4,  4'b1001, 32'h1234,   32'd0,      1'b1, 1'b0);
    runOne("addi",  3'b000, 1'b1, 1'b0, 1'b1, 32'h1234,   32'h9999,       32'h1234,  5'd5,  4'b0100, 32'h1234,   32'h2468,   1'b0, 1'b0);
    runOne("sll",   3'b001, 1'b0, 1'b0, 1'b0, 32'd1,      32'h21,         32'd0,     5'd6,  4'b0011, 32'd1,      32'd2,      1'b0, 1'b0);
    runOne("srai",  3'b101, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'd0,        32'h403,   5'd7,  4'b0000, 32'h403,    32'd0,      1'b1, 1'b1);
    runOne("srl",   3'b101, 1'b0, 1'b0, 1'b0, 32'h80,     32'h24,         32'd0,     5'd8,  4'b1010, 32'd4,      32'h8,      1'b0, 1'b0);
    runOne("mul",   3'b000, 1'b0, 1'b1, 1'b0, 32'd6,      32'd7,          32'd0,     5'd9,  4'b1110, 32'd7,      32'd42,     1'b0, 1'b0);
    runOne("sltu",  3'b011, 1'b0, 1'b0, 1'b0, 32'd1,      32'hFFFFFFFF,   32'd0,     5'd10, 4'b1100, 32'hFFFFFFFF, 32'd1,    1'b0, 1'b0);
    runOne("slt",   3'b010, 1'b0, 1'b0, 1'b0, 32'd3,      32'd5,          32'd0,     5'd11, 4'b0000, 32'd5,      32'd0,      1'b1, 1'b1);
    runOne("and",   3'b111, 1'b0, 1'b0, 1'b0, 32'hFF00,   32'h0FF0,       32'd0,     5'd12, 4'b0001, 32'h0FF0,   32'h0F00,   1'b0, 1'b0);
    runOne("andm",  3'b111, 1'b0, 1'b1, 1'b0, 32'hFF00,   32'hF0,         32'd0,     5'd13, 4'b0000, 32'hF0,     32'd0,      1'b1, 1'b1);
    runOne("or",    3'b110, 1'b0, 1'b0, 1'b0, 32'hF000,   32'h000F,       32'd0,     5'd14, 4'b0010, 32'h000F,   32'hF00F,   1'b0, 1'b0);
    runOne("xor",   3'b100, 1'b0, 1'b0, 1'b0, 32'hF0,     32'hFF,         32'd0,     5'd15, 4'b0111, 32'hFF,     32'h0F,     1'b0, 1'b0);
    runOne("submul",3'b000, 1'b1, 1'b1, 1'b0, 32'd9,      32'd2,          32'd0,     5'd16, 4'b0000, 32'd2,      32'd0,      1'b1, 1'b1);

    // Drain the last result so the pipe is empty.
    tick;
    checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A,B,C,D with out_ready low for the first five cycles.
    // Op k (1..4) is ADD rs1=0x10*k, rs2=k -> result 0x11*k, rd=k.
    nextIn = 0;
    nextOut = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 5);
      if (nextIn < 4) begin
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 32'h10 * (nextIn + 1), nextIn + 1, 32'd0, 5'(nextIn + 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 2) checkOutput("bp_inready_early", {31'd0, in_ready}, 32'd1);
      if (cyc == 2 || cyc == 4) begin
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_hold_res", out_result, 32'h11);
        checkOutput("bp_hold_rd", {27'd0, out_rd}, 32'd1);
        checkOutput("bp_inready_stall", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        checkOutput("bp_order_res", out_result, 32'h11 * (nextOut + 1));
        checkOutput("bp_order_rd", {27'd0, out_rd}, nextOut + 1);
        nextOut++;
      end
      if (in_valid && in_ready) nextIn++;
      tick;
    end
    checkOutput("bp_count", nextOut, 32'd4);
`ifdef ALU_ISSUE_STAGE_PERF_EN
    checkOutput("bp_perf_stall", perfStall, 32'd3);
`endif

    // Reset mid-operation with both stages full.
    out_ready = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd20);
    tick;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 5'd21);
    tick;
    in_valid = 1'b0;
    checkOutput("rmid_pre_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("rmid_pre_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rmid_res", out_result, 32'd0);
    checkOutput("rmid_op", {28'd0, alu_op}, 32'd0);
`ifdef ALU_ISSUE_STAGE_PERF_EN
    checkOutput("rmid_perf_ops", perfOps, 32'd0);
    checkOutput("rmid_perf_stall", perfStall, 32'd0);
`endif
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    validCount = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (out_valid) validCount++;
    end
    checkOutput("rmid_residual", validCount, 32'd0);

    // Full throughput: 8 back-to-back ADDs (k + 100), out_ready held high.
    validCount = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc < 8) begin
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, cyc, 32'd100, 32'd0, 5'(cyc));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc < 8) checkOutput("tp_inready", {31'd0, in_ready}, 32'd1);
      if (cyc >= 2 && cyc < 10) begin
        checkOutput("tp_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("tp_res", out_result, 32'd100 + cyc - 2);
      end
      if (out_valid) validCount++;
      tick;
    end
    checkOutput("tp_count", validCount, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
